// File: rtl/test_check_pattern.sv
// test_check_pattern: receive-side checker for test-pattern frames.
// Filters incoming Ethernet frames on destination MAC and EtherType, checks
// the payload layout byte by byte, tracks packet sequence numbers and keeps
// saturating frame / error / loss counters for debug readout.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   local_mac                 accepted destination MAC (broadcast also accepted)
//   clear_counters            pulse: zero counters and sequence history
//   s_eth_hdr_*               Ethernet header handshake and fields
//   s_eth_payload_axis_*      AXI-Stream payload (8-bit)
//   cur_timestamp             free-running local time (latency option only)
//   last_src_mac              source MAC of the last accepted frame
//   last_packet_num           packet number of the last checked frame
//   rx_packet_count           frames checked
//   rx_error_count            checked frames with at least one error
//   rx_lost_count             accumulated sequence gap
//   frame_done / frame_ok     one-cycle pulse per checked frame, ok qualifier
//   last_latency, max_latency frame latency (latency option only, else 0)
//
// Build option: define TEST_CHECK_LATENCY_EN to build the latency logic.
//
// state        | meaning
// S_IDLE       | waiting for a header; payload not accepted
// S_TYPE_FLAG  | payload byte 0, must equal TYPE_FLAG
// S_TIMESTAMP  | payload bytes 1-2, sender timestamp (big-endian)
// S_3ZEROS     | payload bytes 3-5, must be 0x00
// S_PACKET_NUM | payload bytes 6-7, sequence number (big-endian)
// S_DATA       | data bytes, byte i must equal i[7:0]
// S_DROP       | discard bytes until tlast (filtered or over-long frame)

module test_check_pattern #(
   parameter int          DATA_LENGTH = 64,
   parameter int          DATA_WIDTH  = 8,
   parameter logic [15:0] ETH_TYPE    = 16'h88B5,
   parameter logic [7:0]  TYPE_FLAG   = 8'h01
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [47:0]           local_mac,
   input  logic                  clear_counters,
   input  logic                  s_eth_hdr_valid,
   output logic                  s_eth_hdr_ready,
   input  logic [47:0]           s_eth_dest_mac,
   input  logic [47:0]           s_eth_src_mac,
   input  logic [15:0]           s_eth_type,
   input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
   input  logic                  s_eth_payload_axis_tvalid,
   output logic                  s_eth_payload_axis_tready,
   input  logic                  s_eth_payload_axis_tlast,
   input  logic                  s_eth_payload_axis_tuser,
   input  logic [15:0]           cur_timestamp,
   output logic [47:0]           last_src_mac,
   output logic [15:0]           last_packet_num,
   output logic [31:0]           rx_packet_count,
   output logic [31:0]           rx_error_count,
   output logic [31:0]           rx_lost_count,
   output logic                  frame_done,
   output logic                  frame_ok,
   output logic [15:0]           last_latency,
   output logic [15:0]           max_latency
);

   // Header segments need counts up to 2 even when DATA_LENGTH is tiny.
   localparam int CNT_W = ($clog2(DATA_LENGTH) < 2) ? 2 : $clog2(DATA_LENGTH);

   typedef enum logic [2:0] {
      S_IDLE, S_TYPE_FLAG, S_TIMESTAMP, S_3ZEROS, S_PACKET_NUM, S_DATA, S_DROP
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               err_r;
   logic [15:0]        pkt_num_r;
   logic               pkt_valid_r;
   logic               have_hist;

   logic               beat;
   logic               check_en;
   logic [7:0]         exp_byte;
   logic               byte_err;
   logic               is_final;
   logic               frame_end;
   logic               seg_done;
   state_t             seg_next;
   logic               pkt_last_byte;
   logic [15:0]        pkt_cur;
   logic               pkt_have;
   logic [15:0]        seq_gap;
   logic               seq_err;
   logic               end_err;
   logic [32:0]        lost_sum;
   logic               hdr_match;

   assign s_eth_hdr_ready           = (state == S_IDLE);
   assign s_eth_payload_axis_tready = (state != S_IDLE);

   always_comb begin
      beat      = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
      hdr_match = ((s_eth_dest_mac == local_mac) || (s_eth_dest_mac == 48'hFFFF_FFFF_FFFF))
                  && (s_eth_type == ETH_TYPE);
      check_en  = 1'b0;
      exp_byte  = 8'h00;
      seg_done  = 1'b0;
      seg_next  = state;
      case (state)
         S_TYPE_FLAG: begin
            check_en = 1'b1;
            exp_byte = TYPE_FLAG;
            seg_done = 1'b1;
            seg_next = S_TIMESTAMP;
         end
         S_TIMESTAMP: begin
            seg_done = (cnt == CNT_W'(1));
            seg_next = S_3ZEROS;
         end
         S_3ZEROS: begin
            check_en = 1'b1;
            seg_done = (cnt == CNT_W'(2));
            seg_next = S_PACKET_NUM;
         end
         S_PACKET_NUM: begin
            seg_done = (cnt == CNT_W'(1));
            seg_next = S_DATA;
         end
         S_DATA: begin
            check_en = 1'b1;
            exp_byte = 8'(cnt);
         end
         default: ;
      endcase
      byte_err  = check_en && (s_eth_payload_axis_tdata != exp_byte);
      is_final  = (state == S_DATA) && (cnt == CNT_W'(DATA_LENGTH - 1));
      frame_end = beat && (state inside {S_TYPE_FLAG, S_TIMESTAMP, S_3ZEROS, S_PACKET_NUM, S_DATA})
                  && (s_eth_payload_axis_tlast || is_final);

      // The low packet-number byte may be the terminating byte of a short frame.
      pkt_last_byte = (state == S_PACKET_NUM) && (cnt == CNT_W'(1));
      pkt_cur       = pkt_last_byte ? {pkt_num_r[15:8], s_eth_payload_axis_tdata[7:0]} : pkt_num_r;
      pkt_have      = pkt_valid_r || pkt_last_byte;
      seq_gap       = pkt_cur - last_packet_num - 16'd1;
      seq_err       = have_hist && pkt_have && (seq_gap != 16'd0);

      // tlast != is_final covers both short and over-long frames.
      end_err  = err_r || byte_err || (s_eth_payload_axis_tlast != is_final)
                 || (s_eth_payload_axis_tlast && s_eth_payload_axis_tuser) || seq_err;
      lost_sum = {1'b0, rx_lost_count} + {17'd0, seq_gap};
   end

`ifdef TEST_CHECK_LATENCY_EN
   logic [15:0] ts_r;
   logic [15:0] lat_cur;
   assign lat_cur = cur_timestamp - ts_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_r         <= '0;
         last_latency <= '0;
         max_latency  <= '0;
      end else begin
         if (beat && state == S_TIMESTAMP) begin
            if (cnt == '0) ts_r[15:8] <= s_eth_payload_axis_tdata[7:0];
            else           ts_r[7:0]  <= s_eth_payload_axis_tdata[7:0];
         end
         if (clear_counters) begin
            last_latency <= '0;
            max_latency  <= '0;
         end else if (frame_end) begin
            last_latency <= lat_cur;
            if (!end_err && lat_cur > max_latency) max_latency <= lat_cur;
         end
      end
   end
`else
   logic unused_timestamp;
   assign unused_timestamp = ^cur_timestamp;
   assign last_latency     = '0;
   assign max_latency      = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         cnt             <= '0;
         err_r           <= 1'b0;
         pkt_num_r       <= '0;
         pkt_valid_r     <= 1'b0;
         have_hist       <= 1'b0;
         last_src_mac    <= '0;
         last_packet_num <= '0;
         rx_packet_count <= '0;
         rx_error_count  <= '0;
         rx_lost_count   <= '0;
         frame_done      <= 1'b0;
         frame_ok        <= 1'b0;
      end else begin
         frame_done <= frame_end;
         frame_ok   <= frame_end && !end_err;

         if (state == S_IDLE) begin
            if (s_eth_hdr_valid) begin
               cnt <= '0;
               if (hdr_match) begin
                  state        <= S_TYPE_FLAG;
                  last_src_mac <= s_eth_src_mac;
                  err_r        <= 1'b0;
                  pkt_valid_r  <= 1'b0;
               end else begin
                  state <= S_DROP;
               end
            end
         end else if (beat) begin
            if (state == S_DROP) begin
               if (s_eth_payload_axis_tlast) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end
            end else begin
               err_r <= err_r | byte_err;
               if (state == S_PACKET_NUM) begin
                  if (cnt == '0) pkt_num_r[15:8] <= s_eth_payload_axis_tdata[7:0];
                  else begin
                     pkt_num_r[7:0] <= s_eth_payload_axis_tdata[7:0];
                     pkt_valid_r    <= 1'b1;
                  end
               end
               if (frame_end) begin
                  state <= s_eth_payload_axis_tlast ? S_IDLE : S_DROP;
                  cnt   <= '0;
               end else if (seg_done) begin
                  state <= seg_next;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         end

         // Clear takes priority over a coincident frame end.
         if (clear_counters) begin
            rx_packet_count <= '0;
            rx_error_count  <= '0;
            rx_lost_count   <= '0;
            last_packet_num <= '0;
            have_hist       <= 1'b0;
         end else if (frame_end) begin
            if (rx_packet_count != '1) rx_packet_count <= rx_packet_count + 1'b1;
            if (end_err && rx_error_count != '1) rx_error_count <= rx_error_count + 1'b1;
            if (seq_err) rx_lost_count <= lost_sum[32] ? '1 : lost_sum[31:0];
            if (pkt_have) begin
               last_packet_num <= pkt_cur;
               have_hist       <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_test_check_pattern.sv
module tb_test_check_pattern;

   localparam logic [47:0] MY_MAC  = 48'h02_11_22_33_44_55;
   localparam logic [47:0] SRC_MAC = 48'h02_AA_BB_CC_DD_EE;
   localparam logic [47:0] BC_MAC  = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [15:0] ETYPE   = 16'h88B5;
   localparam int          FLEN    = 72;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear_counters;
   logic        hdr_valid;
   logic        hdr_ready;
   logic [47:0] dest_mac;
   logic [47:0] src_mac;
   logic [15:0] eth_type;
   logic [7:0]  tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic        tuser;
   logic [15:0] cur_timestamp;
   logic [47:0] last_src_mac;
   logic [15:0] last_packet_num;
   logic [31:0] rx_packet_count;
   logic [31:0] rx_error_count;
   logic [31:0] rx_lost_count;
   logic        frame_done;
   logic        frame_ok;
   logic [15:0] last_latency;
   logic [15:0] max_latency;

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt    = 0;
   bit last_ok     = 1'b0;
   int base;

   always #5 clk = ~clk;

   test_check_pattern dut (
      .clk                       (clk),
      .rst                       (rst),
      .local_mac                 (MY_MAC),
      .clear_counters            (clear_counters),
      .s_eth_hdr_valid           (hdr_valid),
      .s_eth_hdr_ready           (hdr_ready),
      .s_eth_dest_mac            (dest_mac),
      .s_eth_src_mac             (src_mac),
      .s_eth_type                (eth_type),
      .s_eth_payload_axis_tdata  (tdata),
      .s_eth_payload_axis_tvalid (tvalid),
      .s_eth_payload_axis_tready (tready),
      .s_eth_payload_axis_tlast  (tlast),
      .s_eth_payload_axis_tuser  (tuser),
      .cur_timestamp             (cur_timestamp),
      .last_src_mac              (last_src_mac),
      .last_packet_num           (last_packet_num),
      .rx_packet_count           (rx_packet_count),
      .rx_error_count            (rx_error_count),
      .rx_lost_count             (rx_lost_count),
      .frame_done                (frame_done),
      .frame_ok                  (frame_ok),
      .last_latency              (last_latency),
      .max_latency               (max_latency)
   );

   always @(negedge clk) begin
      if (frame_done) begin
         done_cnt <= done_cnt + 1;
         last_ok  <= frame_ok;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear_counters = 1'b1;
      @(negedge clk);
      clear_counters = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   // Sends one frame; bad_idx < 0 means no corruption.
   task automatic send_frame(input logic [47:0] dmac, input logic [15:0] typ,
                             input logic [15:0] ts, input logic [15:0] pnum,
                             input int len, input int bad_idx, input bit tuser_last,
                             input bit gaps, input bit clr_last);
      int         w;
      logic [7:0] b;
      w = 0;
      @(negedge clk);
      while (!hdr_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (w >= 200) chk("hdr_wait", 64'd0, 64'd1);
      hdr_valid = 1'b1;
      dest_mac  = dmac;
      src_mac   = SRC_MAC;
      eth_type  = typ;
      @(negedge clk);
      hdr_valid = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (gaps) begin
            tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         case (i)
            0:       b = 8'h01;
            1:       b = ts[15:8];
            2:       b = ts[7:0];
            3, 4, 5: b = 8'h00;
            6:       b = pnum[15:8];
            7:       b = pnum[7:0];
            default: b = 8'(i - 8);
         endcase
         if (i == bad_idx) b = 8'hFF;
         tdata          = b;
         tvalid         = 1'b1;
         tlast          = (i == len - 1);
         tuser          = tuser_last && (i == len - 1);
         clear_counters = clr_last && (i == len - 1);
         @(negedge clk);
      end
      tvalid         = 1'b0;
      tlast          = 1'b0;
      tuser          = 1'b0;
      clear_counters = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst            = 1'b1;
      clear_counters = 1'b0;
      hdr_valid      = 1'b0;
      dest_mac       = '0;
      src_mac        = '0;
      eth_type       = '0;
      tdata          = '0;
      tvalid         = 1'b0;
      tlast          = 1'b0;
      tuser          = 1'b0;
      cur_timestamp  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_hdr_ready", hdr_ready, 1);
      chk("rst_tready", tready, 0);
      chk("rst_pkt_cnt", rx_packet_count, 0);
      chk("rst_err_cnt", rx_error_count, 0);
      chk("rst_lost_cnt", rx_lost_count, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_src_mac", last_src_mac, 0);

      // three good frames 0,1,2
      base = done_cnt;
      for (int p = 0; p < 3; p++)
         send_frame(MY_MAC, ETYPE, 16'h1234, 16'(p), FLEN, -1, 0, 0, 0);
      settle();
      chk("good_done", done_cnt - base, 3);
      chk("good_ok", last_ok, 1);
      chk("good_pkt_cnt", rx_packet_count, 3);
      chk("good_err_cnt", rx_error_count, 0);
      chk("good_lost_cnt", rx_lost_count, 0);
      chk("good_last_pkt", last_packet_num, 2);
      chk("good_src_mac", last_src_mac, SRC_MAC);

      // sequence gap 5 -> 9
      pulse_clear();
      send_frame(MY_MAC, ETYPE, 16'h0000, 16'd5, FLEN, -1, 0, 0, 0);
      send_frame(MY_MAC, ETYPE, 16'h0000, 16'd9, FLEN, -1, 0, 0, 0);
      settle();
      chk("gap_lost_cnt", rx_lost_count, 3);
      chk("gap_ok", last_ok, 0);
      chk("gap_err_cnt", rx_error_count, 1);
      chk("gap_pkt_cnt", rx_packet_count, 2);
      chk("gap_last_pkt", last_packet_num, 9);

      // corrupted data byte 20, short frame, then good frame
      pulse_clear();
      send_frame(MY_MAC, ETYPE, 16'h0000, 16'd0, FLEN, 28, 0, 0, 0);
      settle();
      chk("corrupt_ok", last_ok, 0);
      send_frame(MY_MAC, ETYPE, 16'h0000, 16'd1, 31, -1, 0, 0, 0);
      settle();
      chk("short_ok", last_ok, 0);
      chk("short_hdr_ready", hdr_ready, 1);
      send_frame(MY_MAC, ETYPE, 16'h0000, 16'd2, FLEN, -1, 0, 0, 0);
      settle();
      chk("recover_ok", last_ok, 1);
      chk("recover_pkt_cnt", rx_packet_count, 3);
      chk("recover_err_cnt", rx_error_count, 2);
      chk("recover_lost_cnt", rx_lost_count, 0);
      chk("recover_last_pkt", last_packet_num, 2);

      // filtered frames: wrong type, wrong MAC
      base = done_cnt;
      send_frame(MY_MAC, 16'h0800, 16'h0000, 16'd3, FLEN, -1, 0, 0, 0);
      send_frame(48'h02_00_00_00_00_99, ETYPE, 16'h0000, 16'd3, FLEN, -1, 0, 0, 0);
      settle();
      chk("filt_done", done_cnt - base, 0);
      chk("filt_pkt_cnt", rx_packet_count, 3);
      chk("filt_err_cnt", rx_error_count, 2);
      chk("filt_hdr_ready", hdr_ready, 1);
      chk("filt_tready", tready, 0);

      // gaps, broadcast, wrap, tuser
      pulse_clear();
      send_frame(MY_MAC, ETYPE, 16'h0000, 16'hFFFE, FLEN, -1, 0, 1, 0);
      send_frame(BC_MAC, ETYPE, 16'h0000, 16'hFFFF, FLEN, -1, 0, 1, 0);
      send_frame(MY_MAC, ETYPE, 16'h0000, 16'h0000, FLEN, -1, 0, 1, 0);
      settle();
      chk("wrap_ok", last_ok, 1);
      chk("wrap_lost_cnt", rx_lost_count, 0);
      send_frame(MY_MAC, ETYPE, 16'h0000, 16'h0001, FLEN, -1, 1, 1, 0);
      settle();
      chk("tuser_ok", last_ok, 0);
      chk("tuser_pkt_cnt", rx_packet_count, 4);
      chk("tuser_err_cnt", rx_error_count, 1);
      chk("tuser_last_pkt", last_packet_num, 1);

      // over-long frame, then good frame
      pulse_clear();
      send_frame(MY_MAC, ETYPE, 16'h0000, 16'd0, FLEN + 1, -1, 0, 0, 0);
      settle();
      chk("long_ok", last_ok, 0);
      chk("long_hdr_ready", hdr_ready, 1);
      send_frame(MY_MAC, ETYPE, 16'h0000, 16'd1, FLEN, -1, 0, 0, 0);
      settle();
      chk("long_pkt_cnt", rx_packet_count, 2);
      chk("long_err_cnt", rx_error_count, 1);
      chk("long_recover_ok", last_ok, 1);

      // clear coincident with frame end
      send_frame(MY_MAC, ETYPE, 16'h0000, 16'd2, FLEN, -1, 0, 0, 1);
      settle();
      chk("clr_pkt_cnt", rx_packet_count, 0);
      chk("clr_err_cnt", rx_error_count, 0);
      chk("clr_lost_cnt", rx_lost_count, 0);
      chk("clr_last_pkt", last_packet_num, 0);
      send_frame(MY_MAC, ETYPE, 16'h0000, 16'd7, FLEN, -1, 0, 0, 0);
      settle();
      chk("postclr_pkt_cnt", rx_packet_count, 1);
      chk("postclr_lost_cnt", rx_lost_count, 0);

`ifdef TEST_CHECK_LATENCY_EN
      cur_timestamp = 16'h0010;
      send_frame(MY_MAC, ETYPE, 16'hFFF0, 16'd8, FLEN, -1, 0, 0, 0);
      settle();
      chk("lat_last", last_latency, 16'h0020);
      chk("lat_max", max_latency, 16'h0020);
`else
      chk("lat_last_off", last_latency, 0);
      chk("lat_max_off", max_latency, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/test_check_pattern.md
Name: test_check_pattern

Overview:
- Receive-side checker for the test-pattern frame generator; sits downstream of the Ethernet RX/MAC header-parsing path.
- Consumes Ethernet header plus AXI-Stream payload, filters on destination MAC and EtherType, and checks payload layout byte by byte.
- Tracks sequence numbers to count lost frames and exposes frame/error/loss counters for debug readout.

Parameters:
- DATA_LENGTH, 64: number of data bytes after the 8-byte preamble; minimum 2.
- DATA_WIDTH, 8: payload width; only 8 supported.
- ETH_TYPE, 16'h88B5: accepted EtherType.
- TYPE_FLAG, 8'h01: required value of payload byte 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- local_mac  in  48  accepted destination MAC (FF:FF:FF:FF:FF:FF also accepted)
- clear_counters  in  1  single-cycle pulse zeroing all counters and sequence history
- s_eth_hdr_valid  in  1  header valid
- s_eth_hdr_ready  out  1  header ready
- s_eth_dest_mac  in  48  destination MAC
- s_eth_src_mac  in  48  source MAC, captured only
- s_eth_type  in  16  EtherType
- s_eth_payload_axis_tdata  in  8  payload byte
- s_eth_payload_axis_tvalid  in  1  payload valid
- s_eth_payload_axis_tready  out  1  payload ready
- s_eth_payload_axis_tlast  in  1  last payload byte
- s_eth_payload_axis_tuser  in  1  bad-frame marker, sampled with tlast
- cur_timestamp  in  16  free-running local timestamp (used only with optional feature)
- last_src_mac  out  48  source MAC of last checked frame
- last_packet_num  out  16  packet number of last checked frame
- rx_packet_count  out  32  frames checked (matching MAC/type)
- rx_error_count  out  32  checked frames with at least one error
- rx_lost_count  out  32  accumulated sequence gap
- frame_done  out  1  one-cycle pulse per checked frame
- frame_ok  out  1  qualifies frame_done; 1 means no error
- last_latency  out  16  latency of last frame (optional feature)
- max_latency  out  16  maximum latency since clear (optional feature)

Behaviour:
- Payload layout, big-endian:
  - byte0 = TYPE_FLAG
  - bytes1-2 = timestamp
  - bytes3-5 = 0x00
  - bytes6-7 = packet_num
  - bytes8..8+DATA_LENGTH-1: data byte i = i[7:0]
- Total payload length = DATA_LENGTH+8.
- States: S_IDLE, S_TYPE_FLAG, S_TIMESTAMP, S_3ZEROS, S_PACKET_NUM, S_DATA, S_DROP. A byte counter (clog2(DATA_LENGTH) bits) is cleared on every state change.
- Handshakes:
  - s_eth_hdr_ready = 1 only in S_IDLE.
  - s_eth_payload_axis_tready = 1 in every state except S_IDLE.
  - A byte is consumed only when tvalid && tready; the FSM and counter advance only on a consumed byte.
- Header accept in S_IDLE:
  - Dest MAC matches (local_mac or broadcast) and type == ETH_TYPE: go to S_TYPE_FLAG, capture src MAC, clear the per-frame error flag.
  - Otherwise: go to S_DROP; no counters change.
- Transitions:
  - S_TYPE_FLAG -> S_TIMESTAMP after 1 byte.
  - S_TIMESTAMP -> S_3ZEROS after 2 bytes.
  - S_3ZEROS -> S_PACKET_NUM after 3 bytes.
  - S_PACKET_NUM -> S_DATA after 2 bytes.
  - S_DATA ends after DATA_LENGTH bytes.
- Any consumed byte whose value differs from its expected value sets the error flag.
- Length and tuser rules:
  - tlast on the final data byte: frame ends normally -> S_IDLE.
  - tlast earlier (short frame): error set, frame ends -> S_IDLE.
  - No tlast on the final data byte (long frame): error set, frame ends, -> S_DROP.
  - S_DROP consumes bytes until tlast, then -> S_IDLE, with no further counter effect.
  - tuser=1 with tlast: error set.
- Frame end, registered one cycle after the terminating byte:
  - frame_done pulses; frame_ok = !error.
  - rx_packet_count += 1; rx_error_count += error.
  - last_packet_num is updated. A short frame that ends before both packet_num bytes arrive leaves last_packet_num and the sequence history unchanged.
- Sequence:
  - First frame after reset or clear only records packet_num.
  - Subsequent frames: expected = last+1 mod 2^16. If received != expected, rx_lost_count += (received - expected) mod 2^16 and the frame is marked as an error.
- All counters saturate at 0xFFFFFFFF.
- clear_counters coincident with a frame end: clear wins; that frame is not counted.
- Reset state: FSM in S_IDLE. Every output is 0 except s_eth_hdr_ready = 1 (S_IDLE). A reset mid-frame abandons the frame without counting it.

Optional Feature:
- TEST_CHECK_LATENCY_EN defined:
  - Latency is computed at frame end: last_latency = cur_timestamp - rx_timestamp, mod 2^16, where rx_timestamp is the value captured from payload bytes 1-2.
  - max_latency holds the running maximum over frames with no error; it is cleared by rst or clear_counters.
- TEST_CHECK_LATENCY_EN undefined: last_latency and max_latency are tied to 0, cur_timestamp is ignored, and no latency logic is built.

Test Plan:
- Three correct frames, packet_num 0,1,2, DATA_LENGTH=64 -> three frame_done pulses with frame_ok=1; rx_packet_count=3, rx_error_count=0, rx_lost_count=0, last_packet_num=2.
- Frames with packet_num 5 then 9 -> rx_lost_count=3; second frame frame_ok=0; rx_error_count=1.
- Data byte 20 corrupted to 0xFF, then a frame with tlast at byte 30 -> both counted as errors; the FSM returns to S_IDLE and the next good frame passes.
- Frame with type 0x0800, then one with wrong dest MAC, each of 72 bytes -> all bytes consumed; counters unchanged; no frame_done.
- Random tvalid gaps plus tuser=1 on tlast -> checking unaffected by the gaps; the tuser frame counted as an error. Packet_num wrap 0xFFFF -> 0x0000 gives no loss.
- With TEST_CHECK_LATENCY_EN: rx timestamp 0xFFF0, cur_timestamp 0x0010 at frame end -> last_latency=0x0020, max_latency=0x0020. Also assert clear_counters on the same cycle as a frame end -> all counters 0.
